// File: rtl/mult_bank_pkg.sv
// Shared types and defaults for the multiplier-bank accumulator slice.
package mult_bank_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    FLUSH = 2'd2,
    HOLD  = 2'd3
  } state_t;

  localparam int NUM_LANES_DEF = 4;
  localparam int PROD_W_DEF    = 32;
  localparam int ACC_W_DEF     = 48;
  localparam int LEN_W_DEF     = 16;

  // Width that holds the sum of num_lanes signed prod_w values without wrapping.
  function automatic int lane_sum_w(input int prod_w, input int num_lanes);
    return prod_w + $clog2(num_lanes);
  endfunction

endpackage

// File: rtl/mult_bank_lane_adder.sv
// Combinational signed reduction of one beat of products to a single lane sum.
module mult_bank_lane_adder
  import mult_bank_pkg::*;
#(
  parameter int NUM_LANES = NUM_LANES_DEF,
  parameter int PROD_W    = PROD_W_DEF,
  parameter int SUM_W     = lane_sum_w(PROD_W, NUM_LANES)
) (
  input  logic        [NUM_LANES*PROD_W-1:0] data,
  output logic signed [SUM_W-1:0]            sum
);

  always_comb begin
    sum = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      sum = sum + SUM_W'($signed(data[k*PROD_W +: PROD_W]));
    end
  end

endmodule

// File: rtl/mult_bank_accumulator.sv
// Two-stage lane-sum accumulator with a held result and sticky signed overflow.
//   state | meaning
//   IDLE  | waiting for start
//   ACCUM | accepting product beats
//   FLUSH | stage 2 absorbs the last lane sum
//   HOLD  | result presented until out_ready
module mult_bank_accumulator
  import mult_bank_pkg::*;
#(
  parameter int NUM_LANES = NUM_LANES_DEF,
  parameter int PROD_W    = PROD_W_DEF,
  parameter int ACC_W     = ACC_W_DEF,
  parameter int LEN_W     = LEN_W_DEF
) (
  input  logic                        ACLK,
  input  logic                        ARESET,
  input  logic                        start,
  input  logic [LEN_W-1:0]            cfg_len,
  output logic                        busy,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [NUM_LANES*PROD_W-1:0] in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [ACC_W-1:0]            out_data,
  output logic                        out_ovf
);

  localparam int SUM_W = lane_sum_w(PROD_W, NUM_LANES);

  state_t                  state, state_nxt;
  logic [LEN_W-1:0]        beats_left;
  logic signed [SUM_W-1:0] lane_sum;
  logic signed [SUM_W-1:0] s1_sum;
  logic                    s1_valid;
  logic [ACC_W-1:0]        acc;
  logic [ACC_W-1:0]        s1_ext;
  logic [ACC_W-1:0]        acc_sum;
  logic                    ovf;
  logic                    accept;
  logic                    start_ok;
  logic                    last_beat;
  logic                    add_ovf;

  mult_bank_lane_adder #(
    .NUM_LANES (NUM_LANES),
    .PROD_W    (PROD_W),
    .SUM_W     (SUM_W)
  ) u_lane_adder (
    .data (in_data),
    .sum  (lane_sum)
  );

  assign accept    = in_valid && (state == ACCUM);
  assign start_ok  = start && (state == IDLE);
  assign last_beat = accept && (beats_left == LEN_W'(1));

  assign s1_ext  = ACC_W'(s1_sum);
  assign acc_sum = acc + s1_ext;
  // Signed overflow: like-signed operands producing a differently-signed sum.
  assign add_ovf = (acc[ACC_W-1] == s1_ext[ACC_W-1]) && (acc_sum[ACC_W-1] != acc[ACC_W-1]);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (cfg_len == '0) ? HOLD : ACCUM;
      ACCUM:   if (last_beat) state_nxt = FLUSH;
      FLUSH:   state_nxt = HOLD;
      HOLD:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state      <= IDLE;
      beats_left <= '0;
      s1_valid   <= 1'b0;
      s1_sum     <= '0;
      acc        <= '0;
      ovf        <= 1'b0;
    end else begin
      state    <= state_nxt;
      s1_valid <= accept;
      if (accept) begin
        s1_sum     <= lane_sum;
        beats_left <= beats_left - LEN_W'(1);
      end
      if (start_ok) begin
        beats_left <= cfg_len;
        acc        <= '0;
        ovf        <= 1'b0;
      end else if (s1_valid) begin
        acc <= acc_sum;
        ovf <= ovf | add_ovf;
      end
    end
  end

  assign busy      = (state != IDLE);
  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == HOLD);
  assign out_data  = acc;
  assign out_ovf   = ovf;

endmodule

// File: tb/tb_mult_bank_accumulator.sv
// Randomized and directed checks of the accumulator at ACC_W=48 and ACC_W=34 in lockstep.
module tb_mult_bank_accumulator;
  import mult_bank_pkg::*;

  localparam int NL = 4;
  localparam int PW = 32;
  localparam int LW = 16;

  logic             tb_ACLK = 1'b0;
  logic             ARESET = 1'b1;
  logic             start = 1'b0;
  logic [LW-1:0]    cfg_len = '0;
  logic             in_valid = 1'b0;
  logic [NL*PW-1:0] in_data = '0;
  logic             out_ready = 1'b0;

  logic        busy_a, in_ready_a, out_valid_a, out_ovf_a;
  logic [47:0] out_data_a;
  logic        busy_b, in_ready_b, out_valid_b, out_ovf_b;
  logic [33:0] out_data_b;

  int checks = 0;
  int errors = 0;
  logic [NL*PW-1:0] beats[$];

  always #5 tb_ACLK = ~tb_ACLK;

  mult_bank_accumulator #(.NUM_LANES(NL), .PROD_W(PW), .ACC_W(48), .LEN_W(LW)) dut_a (
    .ACLK(tb_ACLK), .ARESET(ARESET), .start(start), .cfg_len(cfg_len), .busy(busy_a),
    .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a), .out_ovf(out_ovf_a)
  );

  mult_bank_accumulator #(.NUM_LANES(NL), .PROD_W(PW), .ACC_W(34), .LEN_W(LW)) dut_b (
    .ACLK(tb_ACLK), .ARESET(ARESET), .start(start), .cfg_len(cfg_len), .busy(busy_b),
    .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b), .out_ovf(out_ovf_b)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [NL*PW-1:0] pack4(input int l0, input int l1, input int l2, input int l3);
    return {l3, l2, l1, l0};
  endfunction

  // Reference: true integer sums, range-checked and wrapped into a w-bit signed accumulator.
  task automatic model(input int w, output logic [63:0] res, output logic ovf);
    longint acc, nxt, s, m, lo, hi;
    logic [NL*PW-1:0] b;
    logic [PW-1:0] lane;
    m = longint'(1) << w;
    lo = -(m / 2);
    hi = (m / 2) - 1;
    acc = 0;
    ovf = 1'b0;
    foreach (beats[i]) begin
      b = beats[i];
      s = 0;
      for (int k = 0; k < NL; k++) begin
        lane = b[k*PW +: PW];
        s += longint'($signed(lane));
      end
      nxt = acc + s;
      if (nxt > hi || nxt < lo) ovf = 1'b1;
      nxt = nxt % m;
      if (nxt > hi) nxt -= m;
      if (nxt < lo) nxt += m;
      acc = nxt;
    end
    res = 64'(acc) & ((64'd1 << w) - 64'd1);
  endtask

  task automatic run_job(input string tag, input int len, input bit gaps, input int hold, input bit poke);
    logic [63:0] exp_a, exp_b;
    logic        ovf_a, ovf_b, take;
    int          idx, budget;
    model(48, exp_a, ovf_a);
    model(34, exp_b, ovf_b);
    @(negedge tb_ACLK);
    start = 1'b1;
    cfg_len = LW'(len);
    @(posedge tb_ACLK); #1;
    start = 1'b0;
    check({tag, "_busy"}, {busy_a, busy_b}, 2'b11);
    check({tag, "_ready_start"}, {in_ready_a, in_ready_b}, (len == 0) ? 2'b00 : 2'b11);
    check({tag, "_valid_start"}, {out_valid_a, out_valid_b}, (len == 0) ? 2'b11 : 2'b00);
    idx = 0;
    budget = 0;
    while (idx < len && budget < 400) begin
      in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      in_data = beats[idx];
      take = in_valid && in_ready_a;
      @(posedge tb_ACLK); #1;
      budget++;
      if (take) idx++;
    end
    in_valid = 1'b0;
    check({tag, "_beats"}, 64'(idx), 64'(len));
    if (len > 0) begin
      check({tag, "_flush_valid"}, {out_valid_a, out_valid_b}, 2'b00);
      check({tag, "_flush_ready"}, {in_ready_a, in_ready_b}, 2'b00);
      @(posedge tb_ACLK); #1;
    end
    check({tag, "_valid"}, {out_valid_a, out_valid_b}, 2'b11);
    check({tag, "_data48"}, 64'(out_data_a), exp_a);
    check({tag, "_data34"}, 64'(out_data_b), exp_b);
    check({tag, "_ovf"}, {out_ovf_a, out_ovf_b}, {ovf_a, ovf_b});
    for (int c = 0; c < hold; c++) begin
      in_valid = 1'b1;
      if (poke && c == 1) begin
        start = 1'b1;
        cfg_len = LW'(7);
      end
      @(posedge tb_ACLK); #1;
      start = 1'b0;
      check({tag, "_hold_valid"}, {out_valid_a, out_valid_b, in_ready_a, in_ready_b}, 4'b1100);
      check({tag, "_hold_data"}, {out_data_a[15:0], out_data_b, out_ovf_a, out_ovf_b},
            {exp_a[15:0], exp_b[33:0], ovf_a, ovf_b});
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge tb_ACLK); #1;
    out_ready = 1'b0;
    check({tag, "_done"}, {out_valid_a, out_valid_b, busy_a, busy_b}, 4'b0000);
  endtask

  initial begin
    int len;
    logic take;
    repeat (3) @(posedge tb_ACLK);
    #1;
    check("reset_ctrl", {busy_a, in_ready_a, out_valid_a, out_ovf_a, busy_b, in_ready_b, out_valid_b, out_ovf_b}, 8'h00);
    check("reset_data", {16'h0, out_data_a}, {30'h0, out_data_b});
    check("reset_data48", 64'(out_data_a), 64'd0);
    @(negedge tb_ACLK);
    ARESET = 1'b0;

    beats = {pack4(1, 2, 3, 4), pack4(-1, -1, -1, -1), pack4(100, 0, 0, 0)};
    run_job("basic", 3, 1'b0, 0, 1'b0);

    beats = {};
    run_job("len0", 0, 1'b0, 2, 1'b0);

    beats = {pack4(32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF),
             pack4(32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF)};
    run_job("maxpos", 2, 1'b0, 0, 1'b0);
    check("maxpos_ovf34_set", 64'(out_data_a), 64'h3_FFFF_FFF8);

    beats = {pack4(7, -3, 2, 9), pack4(-20, 5, 5, 1), pack4(0, 0, 0, 11)};
    run_job("b2b", 3, 1'b0, 0, 1'b0);

    beats = {};
    for (int i = 0; i < 4; i++) beats.push_back({$urandom, $urandom, $urandom, $urandom});
    run_job("gaps_hold", 4, 1'b1, 5, 1'b1);

    beats = {};
    for (int i = 0; i < 5; i++) beats.push_back({$urandom, $urandom, $urandom, $urandom});
    @(negedge tb_ACLK);
    start = 1'b1;
    cfg_len = LW'(5);
    @(posedge tb_ACLK); #1;
    start = 1'b0;
    len = 0;
    for (int c = 0; c < 40 && len < 2; c++) begin
      in_valid = 1'b1;
      in_data = beats[len];
      take = in_ready_a;
      @(posedge tb_ACLK); #1;
      if (take) len++;
    end
    check("abort_beats", 64'(len), 64'd2);
    #2;
    ARESET = 1'b1;
    in_valid = 1'b0;
    #1;
    check("abort_ctrl", {busy_a, in_ready_a, out_valid_a, busy_b, in_ready_b, out_valid_b}, 6'b000000);
    check("abort_acc", 64'(out_data_a), 64'd0);
    @(negedge tb_ACLK);
    ARESET = 1'b0;
    beats = {pack4(5, 5, 5, 5)};
    run_job("after_abort", 1, 1'b0, 1, 1'b0);

    for (int j = 0; j < 6; j++) begin
      len = $urandom_range(1, 6);
      beats = {};
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 1) == 1) beats.push_back({$urandom, $urandom, $urandom, $urandom});
        else beats.push_back(pack4($urandom_range(0, 999) - 500, $urandom_range(0, 999) - 500,
                                   $urandom_range(0, 999) - 500, $urandom_range(0, 999) - 500));
      end
      run_job("rand", len, 1'b1, $urandom_range(0, 3), 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
